// File: rtl/control_sequencer_if.sv
// Bundle between the control sequencer and the datapath: opcode and flags in,
// control strobes plus the tstate/halted state view out.
interface control_sequencer_if;
  logic [3:0] opcode;
  logic       carry_flag;
  logic       zero_flag;
  logic       pc_inc;
  logic       pc_en;
  logic       pc_ld;
  logic       mar_ld;
  logic       ram_en;
  logic       ram_we;
  logic       ir_ld;
  logic       ir_en;
  logic       a_ld;
  logic       a_en;
  logic       b_ld;
  logic       alu_en;
  logic       alu_sub;
  logic       flags_ld;
  logic       out_ld;
  logic       halted;
  logic [2:0] tstate;

  // No valid/ready here: strobes are level signals, valid for the whole cycle
  // and consumed by the datapath on the next rising clock edge.
  modport master (
    input  opcode, carry_flag, zero_flag,
    output pc_inc, pc_en, pc_ld, mar_ld, ram_en, ram_we, ir_ld, ir_en,
           a_ld, a_en, b_ld, alu_en, alu_sub, flags_ld, out_ld, halted, tstate
  );

  modport slave (
    output opcode, carry_flag, zero_flag,
    input  pc_inc, pc_en, pc_ld, mar_ld, ram_en, ram_we, ir_ld, ir_en,
           a_ld, a_en, b_ld, alu_en, alu_sub, flags_ld, out_ld, halted, tstate
  );
endinterface

// File: rtl/control_sequencer.sv
// Six-T-state microcode sequencer for an 8-bit bus CPU: fetch in T0-T2,
// opcode/flag-dependent execute in T3-T5, sticky halt on HLT.
module control_sequencer (
  input  logic                  clk,
  input  logic                  rst,
  control_sequencer_if.master   bus
);
  typedef enum logic [2:0] {
    T0 = 3'd0, T1 = 3'd1, T2 = 3'd2, T3 = 3'd3, T4 = 3'd4, T5 = 3'd5
  } tstate_e;

  tstate_e state_q, state_d;
  logic    halted_q, halted_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= T0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      halted_q <= halted_d;
    end
  end

  // HLT freezes the counter on T3 rather than letting it advance.
  always_comb begin
    state_d  = state_q;
    halted_d = halted_q;
    if (!halted_q) begin
      case (state_q)
        T0: state_d = T1;
        T1: state_d = T2;
        T2: state_d = T3;
        T3: begin
          if (bus.opcode == 4'hF) halted_d = 1'b1;
          else                    state_d  = T4;
        end
        T4: state_d = T5;
        T5: state_d = T0;
        default: state_d = T0;
      endcase
    end
  end

  logic pc_inc, pc_en, pc_ld, mar_ld, ram_en, ram_we, ir_ld, ir_en;
  logic a_ld, a_en, b_ld, alu_en, alu_sub, flags_ld, out_ld;

  // Gating on rst makes controls drop the instant reset is raised.
  always_comb begin
    pc_inc = 1'b0; pc_en = 1'b0; pc_ld = 1'b0; mar_ld = 1'b0;
    ram_en = 1'b0; ram_we = 1'b0; ir_ld = 1'b0; ir_en = 1'b0;
    a_ld = 1'b0; a_en = 1'b0; b_ld = 1'b0; alu_en = 1'b0;
    alu_sub = 1'b0; flags_ld = 1'b0; out_ld = 1'b0;
    if (!rst && !halted_q) begin
      case (state_q)
        T0: begin pc_en = 1'b1; mar_ld = 1'b1; end
        T1: pc_inc = 1'b1;
        T2: begin ram_en = 1'b1; ir_ld = 1'b1; end
        T3: begin
          case (bus.opcode)
            4'h1, 4'h2, 4'h3, 4'h4: begin ir_en = 1'b1; mar_ld = 1'b1; end
            4'h5: begin ir_en = 1'b1; a_ld = 1'b1; end
            4'h6: begin ir_en = 1'b1; pc_ld = 1'b1; end
            4'h7: if (bus.carry_flag) begin ir_en = 1'b1; pc_ld = 1'b1; end
            4'h8: if (bus.zero_flag) begin ir_en = 1'b1; pc_ld = 1'b1; end
            4'hE: begin a_en = 1'b1; out_ld = 1'b1; end
            default: ;
          endcase
        end
        T4: begin
          case (bus.opcode)
            4'h1: begin ram_en = 1'b1; a_ld = 1'b1; end
            4'h2, 4'h3: begin ram_en = 1'b1; b_ld = 1'b1; end
            4'h4: begin a_en = 1'b1; ram_we = 1'b1; end
            default: ;
          endcase
        end
        T5: begin
          if (bus.opcode == 4'h2 || bus.opcode == 4'h3) begin
            alu_en   = 1'b1;
            a_ld     = 1'b1;
            flags_ld = 1'b1;
            alu_sub  = (bus.opcode == 4'h3);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.pc_inc   = pc_inc;
  assign bus.pc_en    = pc_en;
  assign bus.pc_ld    = pc_ld;
  assign bus.mar_ld   = mar_ld;
  assign bus.ram_en   = ram_en;
  assign bus.ram_we   = ram_we;
  assign bus.ir_ld    = ir_ld;
  assign bus.ir_en    = ir_en;
  assign bus.a_ld     = a_ld;
  assign bus.a_en     = a_en;
  assign bus.b_ld     = b_ld;
  assign bus.alu_en   = alu_en;
  assign bus.alu_sub  = alu_sub;
  assign bus.flags_ld = flags_ld;
  assign bus.out_ld   = out_ld;
  assign bus.halted   = halted_q;
  assign bus.tstate   = state_q;
endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: directed instruction walks plus a long random
// run, all checked against an instruction-level model of the sequencer.
module tb_control_sequencer;
  logic clk;
  logic rst;
  control_sequencer_if bus ();

  control_sequencer dut (.clk(clk), .rst(rst), .bus(bus));

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control bit positions in the packed observation vector.
  localparam logic [14:0] PC_INC = 15'h4000, PC_EN = 15'h2000, PC_LD = 15'h1000;
  localparam logic [14:0] MAR_LD = 15'h0800, RAM_EN = 15'h0400, RAM_WE = 15'h0200;
  localparam logic [14:0] IR_LD = 15'h0100, IR_EN = 15'h0080, A_LD = 15'h0040;
  localparam logic [14:0] A_EN = 15'h0020, B_LD = 15'h0010, ALU_EN = 15'h0008;
  localparam logic [14:0] ALU_SUB = 15'h0004, FLAGS_LD = 15'h0002, OUT_LD = 15'h0001;

  logic [14:0] ctrl;
  assign ctrl = {bus.pc_inc, bus.pc_en, bus.pc_ld, bus.mar_ld, bus.ram_en, bus.ram_we,
                 bus.ir_ld, bus.ir_en, bus.a_ld, bus.a_en, bus.b_ld, bus.alu_en,
                 bus.alu_sub, bus.flags_ld, bus.out_ld};

  int checks = 0;
  int failures = 0;

  // reference model state: T-state number and halted flag
  int m_t;
  bit m_h;

  function automatic logic [14:0] exp_ctrl(int t, int op, bit c, bit z, bit h);
    if (h) return '0;
    if (t == 0) return PC_EN | MAR_LD;
    if (t == 1) return PC_INC;
    if (t == 2) return RAM_EN | IR_LD;
    case (op)
      1: if (t == 3) return IR_EN | MAR_LD; else if (t == 4) return RAM_EN | A_LD;
      2, 3: begin
        if (t == 3) return IR_EN | MAR_LD;
        if (t == 4) return RAM_EN | B_LD;
        if (t == 5) return ALU_EN | A_LD | FLAGS_LD | ((op == 3) ? ALU_SUB : 15'h0);
      end
      4: if (t == 3) return IR_EN | MAR_LD; else if (t == 4) return A_EN | RAM_WE;
      5: if (t == 3) return IR_EN | A_LD;
      6: if (t == 3) return IR_EN | PC_LD;
      7: if (t == 3 && c) return IR_EN | PC_LD;
      8: if (t == 3 && z) return IR_EN | PC_LD;
      14: if (t == 3) return A_EN | OUT_LD;
      default: ;
    endcase
    return '0;
  endfunction

  task automatic chk(string tag, logic [14:0] obs, logic [14:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // driver: check current cycle against the model, then advance one clock
  task automatic step();
    logic [14:0] e;
    #1;
    e = exp_ctrl(m_t, int'(bus.opcode), bus.carry_flag, bus.zero_flag, m_h);
    chk("ctrl", ctrl, e);
    chk("tstate", {12'd0, bus.tstate}, 15'(m_t));
    chk("halted", {14'd0, bus.halted}, {14'd0, m_h});
    @(posedge clk);
    #1;
    if (!m_h) begin
      if (m_t == 3 && bus.opcode == 4'hF) m_h = 1'b1;
      else m_t = (m_t + 1) % 6;
    end
  endtask

  task automatic apply_reset(string tag);
    rst = 1'b1;
    #1;
    m_t = 0;
    m_h = 1'b0;
    chk({tag, "_ctrl"}, ctrl, 15'h0);
    chk({tag, "_tstate"}, {12'd0, bus.tstate}, 15'h0);
    chk({tag, "_halted"}, {14'd0, bus.halted}, 15'h0);
    repeat (2) @(posedge clk);
    #1;
    chk({tag, "_held_ctrl"}, ctrl, 15'h0);
    chk({tag, "_held_tstate"}, {12'd0, bus.tstate}, 15'h0);
    rst = 1'b0;
  endtask

  task automatic run_op(logic [3:0] op, bit c, bit z, int n);
    bus.opcode = op;
    bus.carry_flag = c;
    bus.zero_flag = z;
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    rst = 1'b0;
    bus.opcode = 4'h0;
    bus.carry_flag = 1'b0;
    bus.zero_flag = 1'b0;
    m_t = 0;
    m_h = 1'b0;
    @(posedge clk);
    #2;
    apply_reset("reset");

    // NOP fetch cycle, then the flag-dependent and arithmetic instructions
    run_op(4'h0, 1'b0, 1'b0, 7);
    while (m_t != 0) step();
    run_op(4'h3, 1'b0, 1'b0, 6);
    run_op(4'h7, 1'b0, 1'b0, 6);
    run_op(4'h7, 1'b1, 1'b0, 6);
    run_op(4'h8, 1'b0, 1'b1, 6);
    run_op(4'h8, 1'b1, 1'b0, 6);
    for (int op = 0; op < 15; op++) run_op(op[3:0], op[0], op[1], 6);

    // reset in the middle of ADD's T4
    run_op(4'h2, 1'b0, 1'b0, 4);
    chk("add_at_t4", {12'd0, bus.tstate}, 15'd4);
    apply_reset("mid_add");
    run_op(4'h2, 1'b0, 1'b0, 6);

    // random run with HLT excluded so the sequencer keeps going
    for (int i = 0; i < 10000; i++) begin
      bus.opcode = 4'($urandom_range(0, 14));
      bus.carry_flag = 1'($urandom);
      bus.zero_flag = 1'($urandom);
      #1;
      checks++;
      assert ($countones({bus.pc_en, bus.ram_en, bus.ir_en, bus.a_en, bus.alu_en}) <= 1 &&
              !(bus.pc_inc && bus.pc_ld)) else begin
        failures++;
        $error("FAIL bus_onehot observed=%0h expected=onehot_or_zero", ctrl);
      end
      step();
    end

    // HLT: freeze at T3 with no controls, then recover through reset
    while (m_t != 0) step();
    run_op(4'hF, 1'b1, 1'b1, 4);
    chk("hlt_halted", {14'd0, bus.halted}, 15'd1);
    for (int i = 0; i < 20; i++) begin
      bus.opcode = 4'($urandom_range(0, 15));
      step();
    end
    chk("hlt_frozen_t", {12'd0, bus.tstate}, 15'd3);
    apply_reset("hlt_reset");
    run_op(4'h0, 1'b0, 1'b0, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // watchdog: the directed sequence is far shorter than this
  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end
endmodule
